if_fetch_ctrl: RTL and testbench

//  Instruction-fetch controller between the PC register and the IF/ID pipeline register.

---
 rtl/if_fetch_ctrl_pkg.sv | 27 ++
 rtl/if_fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_if_fetch_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared encodings for the instruction-fetch controller: FSM states, bus size code and the
// exception codes the fetch path can raise alongside the rest of the pipeline's codes.
package if_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } fetch_state_e;

  localparam logic [1:0] SizeWord = 2'b10;

  // Exception codes as written to Cause.ExcCode; fetch only ever raises ExcAdel.
  localparam logic [4:0] ExcInt  = 5'h00;
  localparam logic [4:0] ExcAdel = 5'h04;
  localparam logic [4:0] ExcAdes = 5'h05;
  localparam logic [4:0] ExcSys  = 5'h08;
  localparam logic [4:0] ExcBp   = 5'h09;
  localparam logic [4:0] ExcRi   = 5'h0a;
  localparam logic [4:0] ExcOv   = 5'h0c;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: latches the PC, issues one word read on the SRAM-like inst bus,
// holds the result for decode and pulses pc_en_o when decode takes it.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              inst_req,
  output logic              inst_wr,
  output logic [1:0]        inst_size,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  input  logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  output logic              adel_o,
  output logic              pc_en_o
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              adel_q, adel_d;
  logic              discard_q, discard_d;
  logic              pc_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      inst_q    <= '0;
      valid_q   <= 1'b0;
      adel_q    <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      valid_q   <= valid_d;
      adel_q    <= adel_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    inst_d    = inst_q;
    valid_d   = valid_q;
    adel_d    = adel_q;
    discard_d = discard_q;
    pc_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pc_valid_i && !flush_i) begin
          addr_d = pc_i;
          if (is_misaligned(pc_i[1:0])) begin
            // Misaligned PC never reaches the bus; it is reported as an AdEL slot instead.
            inst_d  = '0;
            adel_d  = 1'b1;
            valid_d = 1'b1;
            state_d = StHold;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        // A request cannot be withdrawn once raised, so a flush only marks the reply stale.
        if (flush_i) begin
          discard_d = 1'b1;
        end
        if (inst_addr_ok) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (inst_data_ok) begin
          if (discard_q || flush_i) begin
            discard_d = 1'b0;
            state_d   = StIdle;
          end else begin
            inst_d  = inst_rdata;
            valid_d = 1'b1;
            state_d = StHold;
          end
        end else if (flush_i) begin
          discard_d = 1'b1;
        end
      end
      StHold: begin
        if (flush_i) begin
          valid_d = 1'b0;
          adel_d  = 1'b0;
          state_d = StIdle;
        end else if (!stall_i) begin
          pc_en   = 1'b1;
          valid_d = 1'b0;
          adel_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign inst_req     = (state_q == StReq);
  assign inst_wr      = 1'b0;
  assign inst_size    = SizeWord;
  assign inst_addr    = inst_req ? addr_q : '0;
  assign inst_o       = inst_q;
  assign inst_pc_o    = addr_q;
  assign inst_valid_o = valid_q;
  assign adel_o       = adel_q;
  assign pc_en_o      = pc_en;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Self-checking bench for if_fetch_ctrl: directed bus handshakes with a scoreboard of
// instructions expected to retire on pc_en_o.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        stall_i;
  logic        flush_i;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        adel_o;
  logic        pc_en_o;

  always #5 clk = ~clk;

  if_fetch_ctrl #(
    .ADDR_W(32),
    .DATA_W(32)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .pc_valid_i  (pc_valid_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .inst_req    (inst_req),
    .inst_wr     (inst_wr),
    .inst_size   (inst_size),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_rdata  (inst_rdata),
    .inst_data_ok(inst_data_ok),
    .inst_o      (inst_o),
    .inst_pc_o   (inst_pc_o),
    .inst_valid_o(inst_valid_o),
    .adel_o      (adel_o),
    .pc_en_o     (pc_en_o)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hs_cnt  = 0;
  int   req_cnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Retirement monitor: every pc_en_o pulse must match the oldest expected instruction.
  always @(negedge clk) begin
    if (!rst) begin
      if (inst_req) req_cnt++;
      if (inst_req && inst_addr_ok) hs_cnt++;
      if (pc_en_o) begin
        check_eq("pcen_vs_flush", {63'd0, flush_i}, 64'd0);
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("ret_inst", {32'd0, inst_o}, {32'd0, mon_e.inst});
          check_eq("ret_pc", {32'd0, inst_pc_o}, {32'd0, mon_e.pc});
          check_eq("ret_adel", {63'd0, adel_o}, {63'd0, mon_e.adel});
          check_eq("ret_valid", {63'd0, inst_valid_o}, 64'd1);
        end
      end
    end
  end

  // One complete fetch; entered and left just after a rising edge with the DUT in idle.
  task automatic fetch(input logic [31:0] pc, input int a_dly, input int d_dly,
                       input logic [31:0] rd, input int stalls, input bit flush_hold);
    int   hs0;
    int   rq0;
    exp_t e;
    hs0 = hs_cnt;
    rq0 = req_cnt;
    pc_i       = pc;
    pc_valid_i = 1'b1;
    @(negedge clk);
    check_eq("idle_no_req", {63'd0, inst_req}, 64'd0);
    tick();
    pc_valid_i = 1'b0;
    if (pc[1:0] != 2'b00) begin
      e = '{inst: 32'h0, pc: pc, adel: 1'b1};
      sb.push_back(e);
      check_eq("adel_no_req", req_cnt - rq0, 0);
    end else begin
      for (int i = 0; i <= a_dly; i++) begin
        inst_addr_ok = (i == a_dly);
        @(negedge clk);
        check_eq("req_held", {63'd0, inst_req}, 64'd1);
        check_eq("req_addr", {32'd0, inst_addr}, {32'd0, pc});
        tick();
      end
      inst_addr_ok = 1'b0;
      for (int i = 0; i <= d_dly; i++) begin
        inst_data_ok = (i == d_dly);
        inst_rdata   = (i == d_dly) ? rd : 32'hdead_beef;
        @(negedge clk);
        check_eq("wait_no_valid", {63'd0, inst_valid_o}, 64'd0);
        check_eq("wait_no_req", {63'd0, inst_req}, 64'd0);
        tick();
      end
      inst_data_ok = 1'b0;
      e = '{inst: rd, pc: pc, adel: 1'b0};
      sb.push_back(e);
      check_eq("one_handshake", hs_cnt - hs0, 1);
      check_eq("req_cycles", req_cnt - rq0, a_dly + 1);
    end
    stall_i = (stalls > 0);
    for (int i = 0; i < stalls; i++) begin
      @(negedge clk);
      check_eq("stall_valid", {63'd0, inst_valid_o}, 64'd1);
      check_eq("stall_no_pcen", {63'd0, pc_en_o}, 64'd0);
      check_eq("stall_inst", {32'd0, inst_o}, {32'd0, e.inst});
      tick();
    end
    stall_i = 1'b0;
    if (flush_hold) begin
      flush_i = 1'b1;
      @(negedge clk);
      check_eq("flush_hold_valid", {63'd0, inst_valid_o}, 64'd1);
      check_eq("flush_hold_no_pcen", {63'd0, pc_en_o}, 64'd0);
      void'(sb.pop_back());
      tick();
      flush_i = 1'b0;
    end else begin
      @(negedge clk);
      check_eq("hold_valid", {63'd0, inst_valid_o}, 64'd1);
      check_eq("hold_pcen", {63'd0, pc_en_o}, 64'd1);
      tick();
    end
    @(negedge clk);
    check_eq("post_no_valid", {63'd0, inst_valid_o}, 64'd0);
    check_eq("post_no_pcen", {63'd0, pc_en_o}, 64'd0);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, {63'd0, inst_req}, 64'd0);
    check_eq({tag, "_wr"}, {63'd0, inst_wr}, 64'd0);
    check_eq({tag, "_size"}, {62'd0, inst_size}, 64'd2);
    check_eq({tag, "_addr"}, {32'd0, inst_addr}, 64'd0);
    check_eq({tag, "_inst"}, {32'd0, inst_o}, 64'd0);
    check_eq({tag, "_pc"}, {32'd0, inst_pc_o}, 64'd0);
    check_eq({tag, "_valid"}, {63'd0, inst_valid_o}, 64'd0);
    check_eq({tag, "_adel"}, {63'd0, adel_o}, 64'd0);
    check_eq({tag, "_pcen"}, {63'd0, pc_en_o}, 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    pc_i         = 32'h0;
    pc_valid_i   = 1'b0;
    stall_i      = 1'b0;
    flush_i      = 1'b0;
    inst_addr_ok = 1'b0;
    inst_rdata   = 32'h0;
    inst_data_ok = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;

    // Minimum-latency fetch from the boot vector.
    fetch(32'hBFC0_0000, 0, 0, 32'h2408_0001, 0, 1'b0);
    // Address acceptance delayed three cycles.
    fetch(32'hBFC0_0004, 3, 0, 32'h2409_0002, 0, 1'b0);

    // Flush while waiting for data; the late reply must be dropped.
    pc_i       = 32'hBFC0_0008;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i   = 1'b0;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    flush_i      = 1'b1;
    @(negedge clk);
    check_eq("wflush_no_valid", {63'd0, inst_valid_o}, 64'd0);
    tick();
    flush_i = 1'b0;
    tick();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h1111_2222;
    @(negedge clk);
    check_eq("wflush_drop_valid", {63'd0, inst_valid_o}, 64'd0);
    tick();
    inst_data_ok = 1'b0;
    @(negedge clk);
    check_eq("wflush_idle_valid", {63'd0, inst_valid_o}, 64'd0);
    check_eq("wflush_idle_req", {63'd0, inst_req}, 64'd0);
    tick();
    fetch(32'hBFC0_0100, 0, 2, 32'h3c1d_a000, 0, 1'b0);

    // Flush while the request is still pending; req must stay up until accepted.
    pc_i       = 32'hBFC0_0200;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i = 1'b0;
    flush_i    = 1'b1;
    @(negedge clk);
    check_eq("rflush_req_kept", {63'd0, inst_req}, 64'd1);
    tick();
    flush_i      = 1'b0;
    inst_addr_ok = 1'b1;
    @(negedge clk);
    check_eq("rflush_req_still", {63'd0, inst_req}, 64'd1);
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h3333_4444;
    tick();
    inst_data_ok = 1'b0;
    @(negedge clk);
    check_eq("rflush_drop_valid", {63'd0, inst_valid_o}, 64'd0);
    tick();

    // Decode stall held for five cycles.
    fetch(32'hBFC0_0104, 0, 1, 32'h8fbf_0010, 5, 1'b0);
    // Misaligned PC reported as AdEL without touching the bus.
    fetch(32'hBFC0_0002, 0, 0, 32'h0, 0, 1'b0);
    fetch(32'hBFC0_0011, 0, 0, 32'h0, 2, 1'b0);
    // Flush of a held instruction must suppress pc_en_o.
    fetch(32'hBFC0_0108, 0, 0, 32'h0320_f809, 2, 1'b1);

    // Reset with a read in flight; the stale reply afterwards must be ignored.
    pc_i       = 32'hBFC0_0300;
    pc_valid_i = 1'b1;
    tick();
    pc_valid_i   = 1'b0;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    rst          = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs("midrst");
    tick();
    rst          = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h5555_6666;
    tick();
    inst_data_ok = 1'b0;
    @(negedge clk);
    check_eq("stale_no_valid", {63'd0, inst_valid_o}, 64'd0);
    check_eq("stale_no_req", {63'd0, inst_req}, 64'd0);
    tick();
    fetch(32'hBFC0_0380, 1, 1, 32'h2402_000a, 1, 1'b0);

    check_eq("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
